// File: rtl/lsu_pkg.sv
// Shared encodings, request record and lane helpers for the load/store unit.
// The lane helpers are pure functions, so the align stage stays purely combinational.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_ACCESS = 2'd1;
    localparam lsu_state_t ST_WRITE  = 2'd2;
    localparam lsu_state_t ST_RESP   = 2'd3;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Little-endian lane select, right-aligned, then sign- or zero-extended.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~is_unsigned}}, b};
            SZ_HALF: r = {{16{h[15] & ~is_unsigned}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word; a word store takes wdata whole.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_BYTE: r[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store merge into the read-back word and load extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_q,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    assign merged    = lane_merge(rd_q, wdata, size, lane);
    assign load_data = lane_extract(rd_q, size, lane, is_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, read-modify-write for sub-word stores,
// fault detection at accept time and a single-cycle registered response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] MEM_LIMIT = MEM_WORDS;

    lsu_state_t  state_q, state_d;
    lsu_req_t    req_q;
    logic        fault_q;
    logic [31:0] rd_q;
    logic        req_fire;
    logic        req_fault;
    logic [31:0] merged;
    logic [31:0] load_data;

    assign req_fire = req_valid && req_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_addr[0];
            SZ_WORD: req_fault = |req_addr[1:0];
            default: req_fault = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= MEM_LIMIT) req_fault = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_fault)                             state_d = ST_RESP;
                    else if (req_write && req_size == SZ_WORD) state_d = ST_WRITE;
                    else                                       state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = req_q.write ? ST_WRITE : ST_RESP;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            fault_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                req_q.write       <= req_write;
                req_q.size        <= req_size;
                req_q.is_unsigned <= req_unsigned;
                req_q.addr        <= req_addr;
                req_q.wdata       <= req_wdata;
                fault_q           <= req_fault;
            end
            if (state_q == ST_ACCESS) rd_q <= mem_read_data;
        end
    end

    lsu_align u_align (
        .rd_q        (rd_q),
        .wdata       (req_q.wdata),
        .size        (req_q.size),
        .lane        (req_q.addr[1:0]),
        .is_unsigned (req_q.is_unsigned),
        .merged      (merged),
        .load_data   (load_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_fault = resp_valid && fault_q;
    assign resp_rdata = (resp_valid && !fault_q && !req_q.write) ? load_data : 32'h0;

    // Strobes decode from state alone; a reset landing on WRITE kills the commit.
    assign mem_address    = {2'b00, req_q.addr[31:2]};
    assign mem_read       = (state_q == ST_ACCESS);
    assign mem_write      = (state_q == ST_WRITE) && !rst;
    assign mem_write_data = (state_q == ST_WRITE) ? merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached data memory, directed scenarios, then random
// requests checked against an arithmetic reference model of memory and responses.
module tb_load_store_unit;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int total = 0;
    int bad   = 0;

    int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, acc_cnt = 0, wr_in_rst = 0;

    logic        mem_init;
    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0: return 32'd3;
            1: return 32'd4;
            2: return 32'd10;
            3: return 32'd28;
            4: return 32'd5;
            5: return 32'd20;
            default: return 32'(i) * 32'h9E37_79B1;
        endcase
    endfunction

    // Data memory: combinational read, write committed at posedge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
        end else if (mem_write && mem_address < WORDS) begin
            mem[mem_address[6:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = (mem_address < WORDS) ? mem[mem_address[6:0]] : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (mem_read)          rd_cnt++;
        if (mem_write)         wr_cnt++;
        if (resp_valid)        resp_cnt++;
        if (rst && mem_write)  wr_in_rst++;
    end
    always @(posedge clk) if (!rst && req_valid && req_ready) acc_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fault(input bit [1:0] sz, input bit [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
            || ((a >> 2) >= WORDS);
    endfunction

    function automatic logic [31:0] ref_load(input bit [31:0] word, input bit [1:0] sz,
                                             input bit uns, input bit [31:0] a);
        bit [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input bit [31:0] old, input bit [31:0] wd,
                                              input bit [1:0] sz, input bit [31:0] a);
        bit [31:0] mask;
        int sh;
        if (sz == 2'd2) return wd;
        sh   = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic do_req(input string tag, input bit w, input bit [1:0] sz, input bit uns,
                          input bit [31:0] a, input bit [31:0] wd);
        bit          flt;
        int          lat, n, r0, w0, p0, a0;
        int unsigned idx;
        logic [31:0] exp_rd;
        flt    = ref_fault(sz, a);
        idx    = a >> 2;
        exp_rd = (flt || w) ? 32'h0 : ref_load(ref_mem[idx], sz, uns, a);
        lat    = flt ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        n = 0;
        while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        r0 = rd_cnt; w0 = wr_cnt; p0 = resp_cnt; a0 = acc_cnt;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 8) begin @(posedge clk); #1; n++; end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_fault"}, 32'(resp_fault), 32'(flt));
        if (w && !flt) ref_mem[idx] = ref_merge(ref_mem[idx], wd, sz, a);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, 32'(req_ready), 32'd1);
        check({tag, "_reads"}, 32'(rd_cnt - r0), 32'(!flt && !(w && sz == 2'd2)));
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(w && !flt));
        check({tag, "_resps"}, 32'(resp_cnt - p0), 32'd1);
        check({tag, "_accepts"}, 32'(acc_cnt - a0), 32'd1);
        if (w && !flt) check({tag, "_memword"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a0, w0, p0;
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst      = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_no_write_in_reset", 32'(wr_in_rst), 32'd0);

        // 1: plain word load
        do_req("t1_lw", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);

        // 2: byte store then both extensions of the stored byte
        do_req("t2_sb", 1'b1, 2'd0, 1'b0, 32'h09, 32'hFF);
        check("t2_word2", mem[2], 32'h0000_FF0A);
        do_req("t2_lbu", 1'b0, 2'd0, 1'b1, 32'h09, 32'h0);
        do_req("t2_lb", 1'b0, 2'd0, 1'b0, 32'h09, 32'h0);

        // 3: upper-half store then both extensions
        do_req("t3_sh", 1'b1, 2'd1, 1'b0, 32'h16, 32'h8001);
        check("t3_word5", mem[5], 32'h8001_0014);
        do_req("t3_lh", 1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        do_req("t3_lhu", 1'b0, 2'd1, 1'b1, 32'h16, 32'h0);

        // 4: every fault class, plus the last valid and first invalid word index
        do_req("t4_lw_mis", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        do_req("t4_sh_mis", 1'b1, 2'd1, 1'b0, 32'h03, 32'h1234);
        do_req("t4_sw_range", 1'b1, 2'd2, 1'b0, 32'h200, 32'h55);
        do_req("t4_size3", 1'b0, 2'd3, 1'b0, 32'h04, 32'h0);
        do_req("t4_lw_last", 1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0);
        do_req("t4_lb_over", 1'b0, 2'd0, 1'b0, 32'h200, 32'h0);

        // 5: valid held high across a sub-word store; second request taken once
        a0 = acc_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h5A;
        @(posedge clk); #1;
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0C; req_wdata = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("t5_busy_ready_c%0d", c), 32'(req_ready), 32'd0);
            check($sformatf("t5_resp_c%0d", c), 32'(resp_valid), 32'(c == 3));
            @(posedge clk); #1;
        end
        check("t5_ready_after_resp", 32'(req_ready), 32'd1);
        ref_mem[4] = ref_merge(ref_mem[4], 32'h5A, 2'd0, 32'h11);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_accepts", 32'(acc_cnt - a0), 32'd2);
        @(posedge clk); #1;
        check("t5_lw_valid", 32'(resp_valid), 32'd1);
        check("t5_lw_rdata", resp_rdata, ref_load(ref_mem[3], 2'd2, 1'b0, 32'h0C));
        @(posedge clk); #1;
        check("t5_accepts_final", 32'(acc_cnt - a0), 32'd2);
        check("t5_word4", mem[4], 32'h0000_5A05);

        // 6: reset lands on the WRITE cycle of a word store
        w0 = wr_cnt; p0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h00; req_wdata = 32'd99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_write_gated", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_ready_after_rst", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_word0", mem[0], 32'd3);
        check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        check("t6_no_resp", 32'(resp_cnt - p0), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);

        // Random mix against the reference model
        for (int k = 0; k < 40; k++) begin
            bit [1:0]  sz;
            bit [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = (32'($urandom_range(0, 131)) << 2) | 32'($urandom_range(0, 3));
            do_req($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), sz,
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int i = 0; i < WORDS; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
